// File: rtl/fifo_pkg.sv
// Types and threshold helpers shared by fifo_sync_prog and the existing FIFO interface users.
package fifo_pkg;

  // Width wide enough for fill counts and thresholds at the largest legal depth (1024).
  localparam int CMP_W = 11;

  typedef struct packed {
    logic empty;
    logic full;
    logic full_next;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic logic fill_at_or_below(input logic [CMP_W-1:0] fill,
                                            input logic [CMP_W-1:0] thresh);
    return fill <= thresh;
  endfunction

  // A zero threshold turns the almost-full flag off entirely.
  function automatic logic fill_at_or_above(input logic [CMP_W-1:0] fill,
                                            input logic [CMP_W-1:0] thresh);
    return (thresh != '0) && (fill >= thresh);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH flop-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read_data = mem_q[read_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, fill level,
// optional first-word-fall-through reads, synchronous flush and sticky error flags.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  clear_errors,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  empty,
  output logic                  full,
  output logic                  full_next,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  import fifo_pkg::*;

  localparam int               PTR_W     = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(1 << ADDR_WIDTH);
  localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      fill_count_q, fill_count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_accept;
  logic                  rd_accept;
  fifo_status_t          status;

  always_comb begin
    status              = '0;
    status.empty        = (fill_count_q == '0);
    status.full         = (fill_count_q == DEPTH_CNT);
    status.full_next    = (fill_count_q == DEPTH_CNT - ONE);
    status.almost_empty = fill_at_or_below(CMP_W'(fill_count_q), CMP_W'(ae_thresh));
    status.almost_full  = fill_at_or_above(CMP_W'(fill_count_q), CMP_W'(af_thresh));
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // Acceptance uses start-of-cycle full/empty, so a read never makes room for a same-cycle write.
  always_comb begin
    wr_accept    = write_en && !status.full && !flush;
    rd_accept    = read_en && !status.empty && !flush;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_count_d = fill_count_q;
    read_data_d  = read_data_q;

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fill_count_d = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + ONE;
      if (wr_accept && !rd_accept) begin
        fill_count_d = fill_count_q + ONE;
      end else if (rd_accept && !wr_accept) begin
        fill_count_d = fill_count_q - ONE;
      end
    end

    if ((FWFT == 0) && rd_accept) begin
      read_data_d = mem_rdata;
    end

    // A fresh error in the clearing cycle keeps its flag set.
    overflow_d  = (overflow_q && !clear_errors) || (write_en && status.full && !flush);
    underflow_d = (underflow_q && !clear_errors) || (read_en && status.empty && !flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      read_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_count_q <= fill_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      read_data_q  <= read_data_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .write_en  (wr_accept),
    .write_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .write_data(write_data),
    .read_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .read_data (mem_rdata)
  );

  // The separate counter must always agree with the wrapped pointer distance.
  fill_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    fill_count_q == PTR_W'(wr_ptr_q - rd_ptr_q));

  assign read_data    = (FWFT != 0) ? mem_rdata : read_data_q;
  assign fill_count   = fill_count_q;
  assign empty        = status.empty;
  assign full         = status.full;
  assign full_next    = status.full_next;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a registered-read and an FWFT instance share stimulus and
// are compared against a queue-based model of the FIFO rules.
module tb_fifo_sync_prog;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_en, read_en, flush, clear_errors;
  logic [DW-1:0] write_data;
  logic [AW:0]   af_thresh, ae_thresh;

  logic [DW-1:0] rd0, rd1;
  logic [AW:0]   fc0, fc1;
  logic          em0, em1, fu0, fu1, fn0, fn1, ae0, ae1, af0, af1, ov0, ov1, un0, un1;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rd;
  int            checks = 0;
  int            errors = 0;

  initial forever #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(rd0), .flush(flush), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .clear_errors(clear_errors), .fill_count(fc0),
    .empty(em0), .full(fu0), .full_next(fn0), .almost_empty(ae0),
    .almost_full(af0), .overflow(ov0), .underflow(un0)
  );

  fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(rd1), .flush(flush), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .clear_errors(clear_errors), .fill_count(fc1),
    .empty(em1), .full(fu1), .full_next(fn1), .almost_empty(ae1),
    .almost_full(af1), .overflow(ov1), .underflow(un1)
  );

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd  = '0;
  endtask

  // Called at posedge+1; drives one cycle, applies the FIFO rules, returns at the next posedge+1.
  task automatic drive_cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                             input logic fl, input logic ce);
    bit was_full, was_empty;
    write_en = we; write_data = wd; read_en = re; flush = fl; clear_errors = ce;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
    end else begin
      if (re && !was_empty) m_rd = q.pop_front();
      if (we && !was_full) q.push_back(wd);
    end
    m_ovf = (m_ovf && !ce) || (we && was_full && !fl);
    m_unf = (m_unf && !ce) || (re && was_empty && !fl);
    #1;
    write_en = 0; read_en = 0; flush = 0; clear_errors = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    write_en = 0; read_en = 0; flush = 0; clear_errors = 0; write_data = '0;
    af_thresh = 3'd3; ae_thresh = 3'd1;
    model_reset();
    #12;
    checks++; if (fc0 !== 3'd0) begin errors++; $display("[TB] FAIL reset_fill got=%0d exp=0", fc0); end
    checks++; if (em0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", em0); end
    checks++; if (fu0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", fu0); end
    checks++; if (fn0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_next got=%b exp=0", fn0); end
    checks++; if (ae0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ae got=%b exp=1", ae0); end
    checks++; if (af0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_af got=%b exp=0", af0); end
    checks++; if ({ov0, un0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_errs got=%b exp=00", {ov0, un0}); end
    checks++; if (rd0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata got=%0h exp=0", rd0); end
    checks++; if ({fc1, em1} !== 4'b0001) begin errors++; $display("[TB] FAIL reset_fwft got=%b exp=0001", {fc1, em1}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_fill();
    logic [DW-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, vals[i], 0, 0, 0);
      checks++; if (fc0 !== 3'(i + 1)) begin errors++; $display("[TB] FAIL fill_count got=%0d exp=%0d", fc0, i + 1); end
      checks++; if (fn0 !== (i == 2)) begin errors++; $display("[TB] FAIL full_next got=%b exp=%b", fn0, i == 2); end
      checks++; if (fu0 !== (i == 3)) begin errors++; $display("[TB] FAIL full got=%b exp=%b", fu0, i == 3); end
    end
    drive_cycle(1, 8'h55, 0, 0, 0);
    checks++; if (ov0 !== 1'b1) begin errors++; $display("[TB] FAIL overflow got=%b exp=1", ov0); end
    checks++; if (fc0 !== 3'd4) begin errors++; $display("[TB] FAIL overflow_fill got=%0d exp=4", fc0); end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("[TB] FAIL overflow_fwft got=%b exp=1", ov1); end
  endtask

  task automatic test_read_drain();
    logic [DW-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    checks++; if (rd1 !== 8'h11) begin errors++; $display("[TB] FAIL fwft_head got=%0h exp=11", rd1); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 1, 0, 0);
      checks++; if (rd0 !== vals[i]) begin errors++; $display("[TB] FAIL drain_data got=%0h exp=%0h", rd0, vals[i]); end
      checks++; if (fc0 !== 3'(3 - i)) begin errors++; $display("[TB] FAIL drain_fill got=%0d exp=%0d", fc0, 3 - i); end
      if (i < 3) begin
        checks++; if (rd1 !== vals[i + 1]) begin errors++; $display("[TB] FAIL fwft_drain got=%0h exp=%0h", rd1, vals[i + 1]); end
      end
    end
    drive_cycle(0, 0, 1, 0, 0);
    checks++; if (un0 !== 1'b1) begin errors++; $display("[TB] FAIL underflow got=%b exp=1", un0); end
    checks++; if (em0 !== 1'b1) begin errors++; $display("[TB] FAIL underflow_empty got=%b exp=1", em0); end
    checks++; if (rd0 !== 8'h44) begin errors++; $display("[TB] FAIL underflow_hold got=%0h exp=44", rd0); end
  endtask

  task automatic test_simultaneous();
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if ({ov0, un0} !== 2'b00) begin errors++; $display("[TB] FAIL clear_errors got=%b exp=00", {ov0, un0}); end
    for (int i = 0; i < 4; i++) drive_cycle(1, DW'($urandom), 0, 0, 0);
    drive_cycle(1, 8'h99, 1, 0, 0);
    checks++; if (fc0 !== 3'd3) begin errors++; $display("[TB] FAIL full_rw_fill got=%0d exp=3", fc0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("[TB] FAIL full_rw_overflow got=%b exp=1", ov0); end
    checks++; if (rd0 !== m_rd) begin errors++; $display("[TB] FAIL full_rw_data got=%0h exp=%0h", rd0, m_rd); end
    drive_cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, DW'($urandom), 1, 0, 0);
      checks++; if (fc0 !== 3'd2) begin errors++; $display("[TB] FAIL half_rw_fill got=%0d exp=2", fc0); end
      checks++; if (rd0 !== m_rd) begin errors++; $display("[TB] FAIL half_rw_data got=%0h exp=%0h", rd0, m_rd); end
      checks++; if (rd1 !== q[0]) begin errors++; $display("[TB] FAIL half_rw_fwft got=%0h exp=%0h", rd1, q[0]); end
    end
  endtask

  task automatic test_thresholds();
    drive_cycle(0, 0, 0, 1, 1);
    af_thresh = 3'd3; ae_thresh = 3'd1;
    #1;
    for (int n = 0; n <= 4; n++) begin
      checks++; if (ae0 !== (n <= 1)) begin errors++; $display("[TB] FAIL almost_empty fill=%0d got=%b exp=%b", n, ae0, n <= 1); end
      checks++; if (af0 !== (n >= 3)) begin errors++; $display("[TB] FAIL almost_full fill=%0d got=%b exp=%b", n, af0, n >= 3); end
      if (n < 4) drive_cycle(1, DW'($urandom), 0, 0, 0);
    end
    af_thresh = 3'd0;
    #1;
    checks++; if (af0 !== 1'b0) begin errors++; $display("[TB] FAIL af_disabled got=%b exp=0", af0); end
    af_thresh = 3'd4; ae_thresh = 3'd4;
    #1;
    checks++; if ({af0, ae0} !== 2'b11) begin errors++; $display("[TB] FAIL thresh_comb got=%b exp=11", {af0, ae0}); end
    af_thresh = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 1, 0, 0);
      checks++; if (af0 !== 1'b0) begin errors++; $display("[TB] FAIL af_disabled_drain got=%b exp=0", af0); end
    end
    af_thresh = 3'd3; ae_thresh = 3'd1;
  endtask

  task automatic test_fwft();
    drive_cycle(0, 0, 0, 1, 1);
    drive_cycle(1, 8'hA5, 0, 0, 0);
    checks++; if (em1 !== 1'b0) begin errors++; $display("[TB] FAIL fwft_empty got=%b exp=0", em1); end
    checks++; if (rd1 !== 8'hA5) begin errors++; $display("[TB] FAIL fwft_first got=%0h exp=a5", rd1); end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, DW'($urandom), 1, 0, 0);
      checks++; if (rd1 !== q[0]) begin errors++; $display("[TB] FAIL fwft_wrap got=%0h exp=%0h", rd1, q[0]); end
      checks++; if (rd0 !== m_rd) begin errors++; $display("[TB] FAIL std_wrap got=%0h exp=%0h", rd0, m_rd); end
    end
  endtask

  task automatic test_flush();
    drive_cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1, DW'($urandom), 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(1, DW'($urandom), 0, 0, 0);
    drive_cycle(1, 8'h77, 0, 1, 0);
    checks++; if (fc0 !== 3'd0) begin errors++; $display("[TB] FAIL flush_fill got=%0d exp=0", fc0); end
    checks++; if (em0 !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got=%b exp=1", em0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("[TB] FAIL flush_overflow got=%b exp=0", ov0); end
    checks++; if (rd0 !== m_rd) begin errors++; $display("[TB] FAIL flush_rdata got=%0h exp=%0h", rd0, m_rd); end
    drive_cycle(1, 8'h77, 1, 1, 0);
    checks++; if ({fc1, un0} !== 4'b0000) begin errors++; $display("[TB] FAIL flush_no_err got=%b exp=0000", {fc1, un0}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        af_thresh = 3'($urandom_range(0, 4));
        ae_thresh = 3'($urandom_range(0, 4));
      end
      drive_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      checks++; if (fc0 !== 3'(q.size())) begin errors++; $display("[TB] FAIL rnd_fill got=%0d exp=%0d", fc0, q.size()); end
      checks++; if (em0 !== (q.size() == 0)) begin errors++; $display("[TB] FAIL rnd_empty got=%b exp=%b", em0, q.size() == 0); end
      checks++; if (fu0 !== (q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_full got=%b exp=%b", fu0, q.size() == DEPTH); end
      checks++; if (fn0 !== (q.size() == DEPTH - 1)) begin errors++; $display("[TB] FAIL rnd_full_next got=%b exp=%b", fn0, q.size() == DEPTH - 1); end
      checks++; if (ae0 !== (q.size() <= int'(ae_thresh))) begin errors++; $display("[TB] FAIL rnd_ae got=%b thr=%0d fill=%0d", ae0, ae_thresh, q.size()); end
      checks++; if (af0 !== (af_thresh != 0 && q.size() >= int'(af_thresh))) begin errors++; $display("[TB] FAIL rnd_af got=%b thr=%0d fill=%0d", af0, af_thresh, q.size()); end
      checks++; if ({ov0, un0} !== {m_ovf, m_unf}) begin errors++; $display("[TB] FAIL rnd_errs got=%b exp=%b", {ov0, un0}, {m_ovf, m_unf}); end
      checks++; if (rd0 !== m_rd) begin errors++; $display("[TB] FAIL rnd_rdata got=%0h exp=%0h", rd0, m_rd); end
      checks++; if (fc1 !== 3'(q.size())) begin errors++; $display("[TB] FAIL rnd_fill_fwft got=%0d exp=%0d", fc1, q.size()); end
      if (q.size() != 0) begin
        checks++; if (rd1 !== q[0]) begin errors++; $display("[TB] FAIL rnd_fwft_data got=%0h exp=%0h", rd1, q[0]); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 0, 0, 1, 1);
    drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(1, 8'h3C, 0, 0, 0);
    drive_cycle(1, 8'h5A, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fc0 !== 3'd0) begin errors++; $display("[TB] FAIL async_fill got=%0d exp=0", fc0); end
    checks++; if ({em0, fu0, fn0, ae0, af0} !== 5'b10010) begin errors++; $display("[TB] FAIL async_flags got=%b exp=10010", {em0, fu0, fn0, ae0, af0}); end
    checks++; if ({ov0, un0} !== 2'b00) begin errors++; $display("[TB] FAIL async_errs got=%b exp=00", {ov0, un0}); end
    checks++; if (rd0 !== 8'h00) begin errors++; $display("[TB] FAIL async_rdata got=%0h exp=0", rd0); end
    checks++; if ({fc1, em1, un1} !== 5'b00010) begin errors++; $display("[TB] FAIL async_fwft got=%b exp=00010", {fc1, em1, un1}); end
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_read_drain();
    test_simultaneous();
    test_thresholds();
    test_fwft();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
